bypass_scoreboard_unit: RTL

//  Next-generation ID-stage hazard/bypass unit. Generates forwarding selects for
//  NUM_RD register read ports across NUM_FWD downstream stages and load-use stalls.
//  It also owns a latency-counting FSM for one long-latency unit (DIV writing HI/LO),

---
 rtl/bypass_scoreboard_unit_pkg.sv | 21 ++
 rtl/bypass_scoreboard_unit_fwd_select.sv | 38 +++
 rtl/bypass_scoreboard_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bypass_scoreboard_unit_pkg.sv
// rtl/bypass_scoreboard_unit_pkg.sv - shared types and helpers for the ID-stage bypass/scoreboard unit
package bypass_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } long_state_e;

    localparam int SRC_RF = 0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bypass_scoreboard_unit_fwd_select.sv
// rtl/bypass_scoreboard_unit_fwd_select.sv - one read port matched against all forwarding stages
module fwd_select
    import bypass_pkg::*;
#(
    parameter int NUM_FWD    = 3,
    parameter int ADDR_W     = 5,
    parameter int LOAD_READY = 2,
    parameter int SRC_W      = 2
) (
    input  logic                      i_rd_en,
    input  logic [ADDR_W-1:0]         i_rd_addr,
    input  logic [NUM_FWD-1:0]        i_fwd_wen,
    input  logic [NUM_FWD*ADDR_W-1:0] i_fwd_waddr,
    input  logic [NUM_FWD-1:0]        i_fwd_is_load,
    output logic [SRC_W-1:0]          o_sel,
    output logic                      o_load_use
);

    logic [SRC_W-1:0] w_sel;
    logic             w_load_use;

    // Scan oldest to youngest so the youngest matching stage overwrites the result.
    always_comb begin
        w_sel      = SRC_W'(SRC_RF);
        w_load_use = 1'b0;
        for (int j = NUM_FWD - 1; j >= 0; j--) begin
            if (i_rd_en && (i_rd_addr != '0) && i_fwd_wen[j] &&
                (i_rd_addr == i_fwd_waddr[j*ADDR_W +: ADDR_W])) begin
                w_sel      = SRC_W'(j + 1);
                w_load_use = i_fwd_is_load[j] && (j < LOAD_READY);
            end
        end
    end

    assign o_sel      = w_sel;
    assign o_load_use = w_load_use;

endmodule

// File: rtl/bypass_scoreboard_unit.sv
// rtl/bypass_scoreboard_unit.sv - forwarding selects, load-use and long-op hazard stalls, stall counter
module bypass_scoreboard_unit
    import bypass_pkg::*;
#(
    parameter int NUM_RD     = 2,
    parameter int NUM_FWD    = 3,
    parameter int ADDR_W     = 5,
    parameter int LOAD_READY = 2,
    parameter int LONG_LAT   = 32,
    localparam int SRC_W     = clog2(NUM_FWD + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_RD-1:0]         i_rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]  i_rd_addr,
    input  logic [NUM_FWD-1:0]        i_fwd_wen,
    input  logic [NUM_FWD*ADDR_W-1:0] i_fwd_waddr,
    input  logic [NUM_FWD-1:0]        i_fwd_is_load,
    input  logic                      i_issue_long,
    input  logic                      i_rd_hilo,
    input  logic                      i_flush,
    output logic [NUM_RD*SRC_W-1:0]   o_rd_src,
    output logic                      o_id_exe_stall,
    output logic                      o_pc_write,
    output logic                      o_ir_write,
    output logic                      o_long_busy,
    output logic                      o_long_done,
    output logic [31:0]               o_stall_cycles
);

    localparam int CNT_W = (clog2(LONG_LAT) < 1) ? 1 : clog2(LONG_LAT);

    logic [NUM_RD-1:0]  w_lu;
    logic               w_long_hz;
    logic               w_stall;
    logic               w_accept;
    long_state_e        r_state;
    long_state_e        w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [31:0]        r_stall_cycles;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        fwd_select #(
            .NUM_FWD    (NUM_FWD),
            .ADDR_W     (ADDR_W),
            .LOAD_READY (LOAD_READY),
            .SRC_W      (SRC_W)
        ) u_fwd_select (
            .i_rd_en       (i_rd_en[i]),
            .i_rd_addr     (i_rd_addr[i*ADDR_W +: ADDR_W]),
            .i_fwd_wen     (i_fwd_wen),
            .i_fwd_waddr   (i_fwd_waddr),
            .i_fwd_is_load (i_fwd_is_load),
            .o_sel         (o_rd_src[i*SRC_W +: SRC_W]),
            .o_load_use    (w_lu[i])
        );
    end

    // In DONE the HI/LO result is forwarded, so only BUSY blocks readers.
    assign w_long_hz = !i_rst && (i_issue_long || i_rd_hilo) && (r_state == ST_BUSY);
    assign w_stall   = (|w_lu) || w_long_hz;
    assign w_accept  = i_issue_long && !w_stall && !i_flush &&
                       ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_flush) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else if (w_accept) begin
            w_state_nxt = ST_BUSY;
            w_cnt_nxt   = CNT_W'(LONG_LAT - 1);
        end else begin
            case (r_state)
                ST_BUSY: begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_long_busy = 1'b0;
        o_long_done = 1'b0;
        case (r_state)
            ST_BUSY: o_long_busy = 1'b1;
            ST_DONE: o_long_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_id_exe_stall = w_stall;
    assign o_pc_write     = !w_stall;
    assign o_ir_write     = !w_stall;
    assign o_stall_cycles = r_stall_cycles;

endmodule
